muldiv_unit: RTL and testbench

Iterative multiply/divide controller that sits beside the ALU in the EXE stage and owns the HI/LO register pair. It accepts MULT/MULTU/DIV/DIVU from EXE, sequences a WIDTH-cycle shift-add / restoring-subtract datapath, and applies sign correction. It raises a stall request so the pipeline holds any instruction that needs the unit or HI/LO while an operation is in flight.

---
 rtl/muldiv_unit.sv | 142 ++++++++++++++
 tb/tb_muldiv_unit.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO pair: WIDTH-cycle shift-add or
// restoring-subtract core, one sign-fix cycle, and a stall request for EXE.
module muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hilo_rd,
  input  logic             wr_hi,
  input  logic             wr_lo,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             stall
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;

  // Operation qualifiers captured at launch
  logic              is_div_p0;
  logic              res_neg_p0;
  logic              rem_neg_p0;
  logic              b_zero_p0;

  // Shared datapath: opnd is multiplicand or divisor; acc is {upper, lower}
  // holding the partial product, or {remainder, dividend/quotient}.
  logic [WIDTH-1:0]   opnd_p0;
  logic [2*WIDTH-1:0] acc_p1;

  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] acc_mul;
  logic [WIDTH:0]     div_shf, div_try;
  logic [2*WIDTH-1:0] acc_div;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   quo_fix, rem_fix;
  logic [WIDTH-1:0]   hi_res, lo_res;

  function automatic logic [WIDTH-1:0] mag(input logic signed [WIDTH-1:0] x,
                                           input logic                    sgn);
    logic signed [WIDTH-1:0] r;
    r = (sgn && x[WIDTH-1]) ? -x : x;
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] neg_w(input logic signed [WIDTH-1:0] x);
    logic signed [WIDTH-1:0] r;
    r = -x;
    return r;
  endfunction

  function automatic logic [2*WIDTH-1:0] neg_dw(input logic signed [2*WIDTH-1:0] x);
    logic signed [2*WIDTH-1:0] r;
    r = -x;
    return r;
  endfunction

  assign a_mag = mag(a, op[0]);
  assign b_mag = mag(b, op[0]);

  assign busy  = (state != IDLE);
  assign stall = busy & (start | hilo_rd | wr_hi | wr_lo);

  // ---- iteration step (RUN) ----
  assign mul_sum = {1'b0, acc_p1[2*WIDTH-1:WIDTH]} + (acc_p1[0] ? {1'b0, opnd_p0} : '0);
  assign acc_mul = {mul_sum, acc_p1[WIDTH-1:1]};

  assign div_shf = {acc_p1[2*WIDTH-1:WIDTH], acc_p1[WIDTH-1]};
  assign div_try = div_shf - {1'b0, opnd_p0};
  assign acc_div = div_try[WIDTH] ? {div_shf[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b0}
                                  : {div_try[WIDTH-1:0], acc_p1[WIDTH-2:0], 1'b1};

  // ---- sign correction (FIX) ----
  // A zero divisor leaves the dividend magnitude as remainder, so the
  // remainder sign fix restores the original a on HI.
  assign prod_fix = res_neg_p0 ? neg_dw(acc_p1) : acc_p1;
  assign quo_fix  = b_zero_p0  ? '1
                  : (res_neg_p0 ? neg_w(acc_p1[WIDTH-1:0]) : acc_p1[WIDTH-1:0]);
  assign rem_fix  = rem_neg_p0 ? neg_w(acc_p1[2*WIDTH-1:WIDTH]) : acc_p1[2*WIDTH-1:WIDTH];
  assign hi_res   = is_div_p0 ? rem_fix : prod_fix[2*WIDTH-1:WIDTH];
  assign lo_res   = is_div_p0 ? quo_fix : prod_fix[WIDTH-1:0];

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (start) state_nxt = RUN;
      RUN:  if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
      FIX:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      done     <= 1'b0;
      div_zero <= 1'b0;
      hi       <= '0;
      lo       <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      if (state == RUN) cnt <= cnt + CW'(1);
      else              cnt <= '0;
      if (state == FIX) begin
        hi       <= hi_res;
        lo       <= lo_res;
        div_zero <= b_zero_p0;
      end else if (state == IDLE) begin
        if (wr_hi) hi <= wdata;
        if (wr_lo) lo <= wdata;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && start) begin
      is_div_p0  <= op[1];
      res_neg_p0 <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
      rem_neg_p0 <= op[0] & a[WIDTH-1];
      b_zero_p0  <= op[1] & (b == '0);
      opnd_p0    <= op[1] ? b_mag : a_mag;
      acc_p1     <= {{WIDTH{1'b0}}, (op[1] ? a_mag : b_mag)};
    end else if (state == RUN) begin
      acc_p1 <= is_div_p0 ? acc_div : acc_mul;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, hazard/reset/back-to-back
// sequences, and random operations against an arithmetic reference model.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rst, start, hilo_rd, wr_hi, wr_lo;
  logic [1:0]  op;
  logic [31:0] a, b, wdata;
  logic [31:0] hi, lo;
  logic        busy, done, div_zero, stall;

  int n_cmp  = 0;
  int n_fail = 0;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .hilo_rd(hilo_rd), .wr_hi(wr_hi), .wr_lo(wr_lo), .wdata(wdata),
    .hi(hi), .lo(lo), .busy(busy), .done(done), .div_zero(div_zero),
    .stall(stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
    logic        dz;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] o, input logic [31:0] x, y,
                                    output logic [31:0] h, output logic [31:0] l,
                                    output logic dz);
    longint sx, sy, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    dz = 1'b0;
    h = '0;
    l = '0;
    case (o)
      2'b00: begin up = {32'b0, x} * {32'b0, y}; h = up[63:32]; l = up[31:0]; end
      2'b01: begin q = sx * sy; h = q[63:32]; l = q[31:0]; end
      default: begin
        if (y == 32'd0) begin
          dz = 1'b1; h = x; l = 32'hFFFF_FFFF;
        end else if (o == 2'b10) begin
          l = x / y; h = x % y;
        end else begin
          q = sx / sy; r = sx % sy; l = q[31:0]; h = r[31:0];
        end
      end
    endcase
  endfunction

  task automatic launch(input logic [1:0] o, input logic [31:0] x, y);
    op = o; a = x; b = y; start = 1'b1;
  endtask

  // Advances clock until done; lat counts edges from the launch edge.
  task automatic wait_done(output int lat, output int bcnt);
    lat = 0; bcnt = 0;
    do begin
      @(posedge clk); #1;
      start = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0; hilo_rd = 1'b0;
      lat++;
      if (busy) bcnt++;
    end while (!done && lat < 60);
  endtask

  task automatic run_check(input string tag, input logic [1:0] o, input logic [31:0] x, y,
                           input logic [31:0] eh, el, input logic edz);
    int lat, bcnt;
    launch(o, x, y);
    wait_done(lat, bcnt);
    check({tag, " latency"}, lat, 34);
    check({tag, " busy_cycles"}, bcnt, 33);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    check({tag, " div_zero"}, div_zero, edz);
  endtask

  initial begin
    logic [31:0] eh, el, eh2, el2;
    logic        edz, edz2;
    int          lat, bcnt, ndone;
    logic [1:0]  ro;
    logic [31:0] ra, rb;

    vecs[0] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0};
    vecs[1] = '{2'b01, 32'hFFFF_FFF9, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[2] = '{2'b11, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3] = '{2'b10, 32'd100,       32'h0000_0000, 32'd100,       32'hFFFF_FFFF, 1'b1};
    vecs[4] = '{2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[5] = '{2'b11, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[6] = '{2'b10, 32'hFFFF_FFFF, 32'h0000_0002, 32'h0000_0001, 32'h7FFF_FFFF, 1'b0};
    vecs[7] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[8] = '{2'b11, 32'hFFFF_FFFB, 32'h0000_0000, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1};
    vecs[9] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 32'h0000_0001, 32'h2345_6780, 1'b0};

    rst = 1'b1; start = 1'b0; hilo_rd = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
    op = '0; a = '0; b = '0; wdata = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset hi", hi, 0);
    check("reset lo", lo, 0);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset div_zero", div_zero, 0);
    check("reset stall", stall, 0);

    for (int i = 0; i < 10; i++) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].hi, vecs[i].lo, vecs[i].dz);
      @(posedge clk); #1;
      check($sformatf("vec%0d done_pulse_width", i), done, 0);
    end

    // MTLO in IDLE
    wr_lo = 1'b1; wdata = 32'h55;
    #1 check("idle mtlo stall", stall, 0);
    @(posedge clk); #1 wr_lo = 1'b0;
    check("idle mtlo lo", lo, 32'h55);

    // start together with MTHI: write lands now, result overwrites later
    launch(2'b00, 32'h0001_2345, 32'h0010_0000);
    wr_hi = 1'b1; wdata = 32'hAAAA; hilo_rd = 1'b1;
    #1 check("idle start stall", stall, 0);
    @(posedge clk); #1;
    start = 1'b0; wr_hi = 1'b0; hilo_rd = 1'b0;
    check("start+mthi hi", hi, 32'hAAAA);
    check("launch busy", busy, 1);
    hilo_rd = 1'b1;
    #1 check("busy mfhi stall", stall, 1);
    hilo_rd = 1'b0; wr_hi = 1'b1; wdata = 32'h1234;
    #1 check("busy mthi stall", stall, 1);
    @(posedge clk); #1 wr_hi = 1'b0;
    check("busy mthi ignored", hi, 32'hAAAA);
    check("busy partial lo hidden", lo, 32'h55);
    wait_done(lat, bcnt);
    ref_model(2'b00, 32'h0001_2345, 32'h0010_0000, eh, el, edz);
    check("hazard op hi", hi, eh);
    check("hazard op lo", lo, el);

    // Back-to-back: second start issued in the done cycle
    ref_model(2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, eh, el, edz);
    ref_model(2'b11, 32'h8765_4321, 32'h0000_1235, eh2, el2, edz2);
    run_check("b2b first", 2'b01, 32'hDEAD_BEEF, 32'h0BAD_F00D, eh, el, edz);
    run_check("b2b second", 2'b11, 32'h8765_4321, 32'h0000_1235, eh2, el2, edz2);

    // Reset at RUN cycle 10 aborts the operation
    launch(2'b10, 32'hFFFF_0000, 32'h0000_0003);
    @(posedge clk); #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check("abort hi", hi, 0);
    check("abort lo", lo, 0);
    check("abort busy", busy, 0);
    ndone = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("abort no done", ndone, 0);

    // Random operations against the reference model
    for (int i = 0; i < 150; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom();
      case ($urandom_range(0, 5))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 20));
        2: rb = 32'hFFFF_FFFF;
        3: rb = -32'($urandom_range(1, 20));
        default: rb = $urandom();
      endcase
      if ($urandom_range(0, 7) == 0) ra = 32'h8000_0000;
      ref_model(ro, ra, rb, eh, el, edz);
      launch(ro, ra, rb);
      wait_done(lat, bcnt);
      check($sformatf("rand%0d op%0d a=%h b=%h latency", i, ro, ra, rb), lat, 34);
      check($sformatf("rand%0d op%0d a=%h b=%h hi", i, ro, ra, rb), hi, eh);
      check($sformatf("rand%0d op%0d a=%h b=%h lo", i, ro, ra, rb), lo, el);
      check($sformatf("rand%0d op%0d a=%h b=%h div_zero", i, ro, ra, rb), div_zero, edz);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
